// File: rtl/aes_round_seq.sv
// AES round sequencer: accepts a block/key, steps a round core through NR rounds, then returns the result.
// Optional scope trigger output `trig` is enabled by defining AES_ROUND_SEQ_TRIGGER_EN.
module aes_round_seq #(
  parameter int DATA_W     = 128,
  parameter int KEY_W      = 256,
  parameter int MAX_ROUNDS = 14   // must be at least 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [1:0]        key_len,
  output logic [DATA_W-1:0] core_data,
  output logic [KEY_W-1:0]  core_key,
  output logic              first_round,
  output logic              final_round,
  output logic [7:0]        round_const,
  input  logic [DATA_W-1:0] core_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              cfg_err,
  output logic [1:0]        state_dbg
`ifdef AES_ROUND_SEQ_TRIGGER_EN
  ,
  output logic              trig
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid stays high with stable out_data until taken.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUND   = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  localparam int CW = $clog2(MAX_ROUNDS + 1);

  state_t            state_q;
  logic [CW-1:0]     rcnt_q;
  logic [CW-1:0]     nr_q;
  logic [CW-1:0]     nr_d;
  logic [CW-1:0]     last_rnd;
  logic [DATA_W-1:0] data_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              first_q;
  logic              final_q;
  logic [7:0]        rc_q;
  logic              cfg_err_q;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1 yields the next round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  always_comb begin
    nr_d = CW'(10);
    case (key_len)
      2'b01:   nr_d = CW'(12);
      2'b10:   nr_d = CW'(14);
      default: nr_d = CW'(10);
    endcase
  end

  assign last_rnd = nr_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      nr_q        <= '0;
      data_q      <= '0;
      key_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      final_q     <= 1'b0;
      rc_q        <= 8'h00;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (key_len == 2'b11) begin
              cfg_err_q <= 1'b1;
            end else begin
              data_q  <= in_data;
              key_q   <= in_key;
              nr_q    <= nr_d;
              rcnt_q  <= '0;
              first_q <= 1'b1;
              final_q <= 1'b0;
              rc_q    <= 8'h01;
              state_q <= ROUND;
            end
          end
        end
        ROUND: begin
          first_q <= 1'b0;
          if (rcnt_q == last_rnd) begin
            final_q <= 1'b0;
            rc_q    <= 8'h00;
            state_q <= CAPTURE;
          end else begin
            rcnt_q  <= rcnt_q + 1'b1;
            final_q <= ((rcnt_q + 1'b1) == last_rnd);
            rc_q    <= xtime(rc_q);
          end
        end
        CAPTURE: begin
          out_data_q  <= core_out;
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign core_data   = data_q;
  assign core_key    = key_q;
  assign first_round = first_q;
  assign final_round = final_q;
  assign round_const = rc_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign cfg_err     = cfg_err_q;
  assign state_dbg   = state_q;

`ifdef AES_ROUND_SEQ_TRIGGER_EN
  assign trig = (state_q == ROUND);
`endif

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: round sequencing, latency, backpressure, cfg_err and reset.
module tb_aes_round_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [255:0] in_key;
  logic [1:0]   key_len;
  logic [127:0] core_data;
  logic [255:0] core_key;
  logic         first_round;
  logic         final_round;
  logic [7:0]   round_const;
  logic [127:0] core_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         cfg_err;
  logic [1:0]   state_dbg;
`ifdef AES_ROUND_SEQ_TRIGGER_EN
  logic         trig;
`endif

  int total = 0;
  int bad   = 0;

  // Hand-written round constants, indexed by round number.
  logic [7:0] rc_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                              8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  localparam logic [1:0] S_IDLE = 2'd0, S_ROUND = 2'd1, S_CAPTURE = 2'd2, S_OUTPUT = 2'd3;

  aes_round_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .key_len(key_len),
    .core_data(core_data), .core_key(core_key),
    .first_round(first_round), .final_round(final_round), .round_const(round_const),
    .core_out(core_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .cfg_err(cfg_err), .state_dbg(state_dbg)
`ifdef AES_ROUND_SEQ_TRIGGER_EN
    , .trig(trig)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 256'(state_dbg), 256'(S_IDLE));
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_in_ready"}, 256'(in_ready), 256'd1);
    chk({tag, "_out_valid"}, 256'(out_valid), 256'd0);
    chk({tag, "_out_data"}, 256'(out_data), 256'd0);
    chk({tag, "_core_data"}, 256'(core_data), 256'd0);
    chk({tag, "_core_key"}, core_key, 256'd0);
    chk({tag, "_ctrl"}, 256'({first_round, final_round, round_const, cfg_err}), 256'd0);
`ifdef AES_ROUND_SEQ_TRIGGER_EN
    chk({tag, "_trig"}, 256'(trig), 256'd0);
`endif
  endtask

  // driver: one full request, checking every ROUND cycle, CAPTURE, OUTPUT hold and release
  task automatic do_req(input string tag, input logic [1:0] kl, input logic [127:0] d,
                        input logic [255:0] k, input int nr, input logic [127:0] cap,
                        input int hold);
    logic [127:0] exp_q[$];
    logic [127:0] expv;
    chk({tag, "_idle_ready"}, 256'(in_ready), 256'd1);
    in_valid = 1'b1; in_data = d; in_key = k; key_len = kl;
    step();                                   // handshake edge T
    in_valid = 1'b0;
    exp_q.push_back(cap);
    for (int r = 0; r < nr; r++) begin
      chk($sformatf("%s_r%0d_state", tag, r), 256'(state_dbg), 256'(S_ROUND));
      chk($sformatf("%s_r%0d_first", tag, r), 256'(first_round), 256'(r == 0));
      chk($sformatf("%s_r%0d_final", tag, r), 256'(final_round), 256'(r == nr - 1));
      chk($sformatf("%s_r%0d_rc", tag, r), 256'(round_const), 256'(rc_tab[r]));
      chk($sformatf("%s_r%0d_busy_rdy", tag, r), 256'({busy, in_ready}), 256'(2'b10));
`ifdef AES_ROUND_SEQ_TRIGGER_EN
      chk($sformatf("%s_r%0d_trig", tag, r), 256'(trig), 256'd1);
`endif
      // a request arriving mid-flight must be dropped
      if (r == 2) begin
        in_valid = 1'b1; in_data = ~d; in_key = ~k; key_len = 2'b10;
      end else begin
        in_valid = 1'b0;
      end
      core_out = 128'($urandom_range(0, 32'hFFFF_FFFF)) ^ 128'hDEAD;
      step();
    end
    in_valid = 1'b0;
    chk({tag, "_capture_state"}, 256'(state_dbg), 256'(S_CAPTURE));
    chk({tag, "_capture_ctrl"}, 256'({first_round, final_round, round_const, out_valid}), 256'd0);
    chk({tag, "_core_data"}, 256'(core_data), 256'(d));
    chk({tag, "_core_key"}, core_key, k);
`ifdef AES_ROUND_SEQ_TRIGGER_EN
    chk({tag, "_capture_trig"}, 256'(trig), 256'd0);
`endif
    core_out = cap;
    step();                                   // edge T+NR+1
    core_out = ~cap;
    expv = exp_q.pop_front();
    chk({tag, "_out_valid"}, 256'(out_valid), 256'd1);
    chk({tag, "_out_data"}, 256'(out_data), 256'(expv));
    for (int h = 0; h < hold; h++) begin
      core_out = 128'($urandom_range(0, 32'hFFFF_FFFF));
      step();
      chk($sformatf("%s_hold%0d_valid", tag, h), 256'(out_valid), 256'd1);
      chk($sformatf("%s_hold%0d_data", tag, h), 256'(out_data), 256'(expv));
    end
    out_ready = 1'b1;
    step();                                   // out handshake edge
    out_ready = 1'b0;
    chk({tag, "_released_valid"}, 256'(out_valid), 256'd0);
    chk({tag, "_released_idle"}, 256'(state_dbg), 256'(S_IDLE));
    chk({tag, "_released_busy"}, 256'(busy), 256'd0);
    chk({tag, "_latched_data"}, 256'(core_data), 256'(d));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_key = '0; key_len = 2'b00;
    core_out = '0; out_ready = 1'b0;
    step(); step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // 128-bit key, all-ones block
    do_req("k128", 2'b00, {128{1'b1}}, 256'd0, 10, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0);
    // 256-bit key with 5 cycles of backpressure
    do_req("k256", 2'b10, 128'h00112233_44556677_8899AABB_CCDDEEFF,
           256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F,
           14, 128'h8EA2B7CA_516745BF_EAFC4990_4B496089, 5);
    // 192-bit key, right-aligned in the key register
    do_req("k192", 2'b01, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0,
           {64'd0, 192'h8E73B0F7_DA0E6452_C810F32B_809079E5_62F8EAD2_522C6B7B},
           12, 128'hDDA97CA4_864CDFE0_6EAF70A0_EC0D7191, 1);

    // invalid key length: one-cycle cfg_err, nothing latched
    in_valid = 1'b1; key_len = 2'b11; in_data = '1; in_key = '1;
    step();
    in_valid = 1'b0;
    chk("cfg_err_pulse", 256'(cfg_err), 256'd1);
    chk("cfg_err_busy", 256'(busy), 256'd0);
    chk("cfg_err_ready", 256'(in_ready), 256'd1);
    chk("cfg_err_nolatch", 256'(core_data), 256'(128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0));
    step();
    chk("cfg_err_drop", 256'(cfg_err), 256'd0);

    // reset in the middle of ROUND at rcnt=4
    in_valid = 1'b1; key_len = 2'b00; in_data = 128'hCAFE; in_key = 256'hBEEF;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("mid_round_rc4", 256'(round_const), 256'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("mid_reset");

    // reset wins over a simultaneous handshake
    rst = 1'b1; in_valid = 1'b1; key_len = 2'b10; in_data = 128'h55; in_key = 256'h66;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk_reset_outputs("rst_prio");

    do_req("after_rst", 2'b00, 128'h3243F6A8_885A308D_313198A2_E0370734,
           256'h2B7E1516_28AED2A6_ABF71588_09CF4F3C, 10, 128'h3925841D_02DC09FB_DC118597_196A0B32, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog: the directed sequence is a few hundred cycles at most
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
